led_fader: RTL and testbench

- Sits directly downstream of the LED chaser pattern generator and drives the board LED pins.
- Converts the chaser's 8-bit on/off pattern into PWM brightness per LED.
- A lit LED jumps to full brightness. Once its input drops, brightness decays in steps at a prescaled tick rate, so the moving dot leaves a fading trail.
- Single clock domain, same clk as the chaser.

---
 rtl/led_pkg.sv | 12 +
 rtl/led_pwm_channel.sv | 55 +++++
 rtl/led_fader.sv | 79 +++++++
 tb/tb_led_fader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED definitions used by the chaser and the fader so both agree on
// the channel count and brightness resolution.
package led_pkg;

  localparam int LED_COUNT = 8;
  localparam int PWM_BITS  = 8;
  localparam int LEVEL_MAX = (2 ** PWM_BITS) - 1;

  typedef logic [PWM_BITS-1:0]  level_t;
  typedef logic [LED_COUNT-1:0] led_vec_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One fader channel: a brightness level that snaps to full while lit and
// decays on each tick otherwise, compared against the shared PWM counter.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int CH_BITS    = PWM_BITS,
  parameter int DECAY_STEP = 8
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               lit,
  input  logic               tick,
  input  logic [CH_BITS-1:0] pwm_cnt,
  input  logic               enable,
  output logic               pwm_out
);

  localparam logic [CH_BITS-1:0] LEVEL_FULL = '1;
  localparam logic [CH_BITS-1:0] STEP       = CH_BITS'(DECAY_STEP);

  logic [CH_BITS-1:0] level_d;
  logic [CH_BITS-1:0] level_q;
  logic               pwm_out_d;
  logic               pwm_out_q;

  // A lit input outranks a coincident tick; decay saturates at zero.
  always_comb begin
    level_d   = level_q;
    pwm_out_d = enable && (pwm_cnt < level_q);
    if (lit) begin
      level_d = LEVEL_FULL;
    end else if (tick) begin
      if (level_q > STEP) begin
        level_d = level_q - STEP;
      end else begin
        level_d = '0;
      end
    end else begin
      level_d = level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      level_q   <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/led_fader.sv
// Turns the chaser's on/off pattern into per-LED PWM with a decaying trail;
// the prescaler and PWM counter are shared by all channels.
module led_fader #(
  parameter int N_LEDS     = led_pkg::LED_COUNT,
  parameter int PWM_BITS   = led_pkg::PWM_BITS,
  parameter int TICK_DIV   = 65536,
  parameter int DECAY_STEP = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [N_LEDS-1:0] led_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out
);

  localparam int LEVEL_MAX = (2 ** PWM_BITS) - 1;
  localparam int PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'(LEVEL_MAX - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("led_fader: TICK_DIV must be at least 2");
  end
  if ((DECAY_STEP < 1) || (DECAY_STEP > LEVEL_MAX)) begin : g_bad_decay_step
    $error("led_fader: DECAY_STEP must lie in 1..LEVEL_MAX");
  end

  logic [N_LEDS-1:0]   led_d;
  logic [N_LEDS-1:0]   led_q;
  logic [PRESC_W-1:0]  presc_d;
  logic [PRESC_W-1:0]  presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                tick;

  // The PWM period is LEVEL_MAX cycles so a full level never drops low.
  always_comb begin
    led_d = led_in;
    tick  = (presc_q == PRESC_LAST);
    if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      led_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      led_q     <= led_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_pwm_channel #(
      .CH_BITS    (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk     (clk),
      .nreset  (nreset),
      .lit     (led_q[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt_q),
      .enable  (enable),
      .pwm_out (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench: a fast-tick fader driven from a cycle table and a slow-tick
// fader measured over whole PWM windows.
module tb_led_fader;
  import led_pkg::*;

  typedef struct {
    led_vec_t led_in;
    logic     en;
    led_vec_t exp_out;
  } vec_t;

  logic     clk = 1'b0;
  logic     nreset;
  led_vec_t led_in_f, led_in_s, out_f, out_s;
  logic     en_f, en_s;
  vec_t     tbl[24];
  int       checks = 0;
  int       failures = 0;
  int       k = 0;
  int       hi_cnt[8];
  int       miss;

  always #5 clk = ~clk;

  led_fader #(.N_LEDS(8), .PWM_BITS(8), .TICK_DIV(4), .DECAY_STEP(64)) dut_fast (
    .clk(clk), .nreset(nreset), .led_in(led_in_f), .enable(en_f), .led_out(out_f));

  led_fader #(.N_LEDS(8), .PWM_BITS(8), .TICK_DIV(1024), .DECAY_STEP(64)) dut_slow (
    .clk(clk), .nreset(nreset), .led_in(led_in_s), .enable(en_s), .led_out(out_s));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) adv();
  endtask

  task automatic fill(input int lo, input int hi, input led_vec_t li, input logic en,
                      input led_vec_t exp);
    for (int i = lo; i <= hi; i++) begin
      tbl[i].led_in  = li;
      tbl[i].en      = en;
      tbl[i].exp_out = exp;
    end
  endtask

  // Count high cycles per channel of the slow fader over edges start..start+len-1.
  task automatic window(input int start, input int len);
    run_to(start);
    for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
    repeat (len) begin
      adv();
      for (int c = 0; c < 8; c++) if (out_s[c]) hi_cnt[c]++;
    end
  endtask

  initial begin
    // Edge k (k=0 is the first edge with nreset high): pwm_cnt before it is
    // k mod 255, a fast tick decays levels at k%4==3, slow at k%1024==1023.
    fill(0, 1,   8'h89, 1'b1, 8'h00);
    fill(2, 3,   8'h89, 1'b1, 8'h89);
    fill(4, 7,   8'h80, 1'b1, 8'h89);
    fill(8, 9,   8'hA0, 1'b1, 8'h89);
    fill(10, 11, 8'h80, 1'b1, 8'hA9);
    fill(12, 13, 8'h80, 1'b0, 8'h00);
    fill(14, 17, 8'h80, 1'b1, 8'hA9);
    fill(18, 18, 8'h88, 1'b1, 8'hA9);
    fill(19, 19, 8'h80, 1'b1, 8'hA9);
    fill(20, 23, 8'h80, 1'b1, 8'hA8);

    nreset   = 1'b0;
    led_in_f = 8'hFF;
    led_in_s = 8'hFF;
    en_f     = 1'b1;
    en_s     = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_fast_out", out_f, 8'h00);
      check("reset_slow_out", out_s, 8'h00);
    end

    nreset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      led_in_f = tbl[i].led_in;
      en_f     = tbl[i].en;
      adv();
      check($sformatf("fast_vec%0d", i), out_f, tbl[i].exp_out);
      check($sformatf("slow_release_vec%0d", i), out_s, (i >= 2) ? 8'hFF : 8'h00);
    end

    // Channel 0 held lit: full brightness every cycle.
    led_in_s = 8'h01;
    miss = 0;
    while (k < 624) begin
      adv();
      if (!out_s[0]) miss++;
    end
    check("full_on_ch0_low_cycles", miss, 0);

    // Release channel 0; levels step 191, 127, 63 on successive slow ticks.
    run_to(1000);
    led_in_s = 8'h00;
    window(1100, 255);
    check("decay_duty_191", hi_cnt[0], 191);
    window(2100, 255);
    check("decay_duty_127", hi_cnt[0], 127);
    window(3100, 255);
    check("decay_duty_63", hi_cnt[0], 63);

    // Level 0 must stay 0 through a further tick rather than wrapping.
    run_to(4096);
    miss = 0;
    repeat (1205) begin
      adv();
      if (out_s != 8'h00) miss++;
    end
    check("saturate_zero_high_cycles", miss, 0);

    // Enable off while lit channels fade, then back on after two ticks.
    run_to(5400);
    led_in_s = 8'hAA;
    run_to(5500);
    led_in_s = 8'h00;
    en_s     = 1'b0;
    miss = 0;
    while (k < 7200) begin
      adv();
      if (out_s != 8'h00) miss++;
    end
    check("disabled_high_cycles", miss, 0);
    en_s = 1'b1;
    adv();
    check("reenable_latency", out_s, 8'hAA);
    window(7300, 255);
    for (int c = 0; c < 8; c++)
      check($sformatf("reenable_duty_ch%0d", c), hi_cnt[c], (c % 2 == 1) ? 127 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
